// File: rtl/lms_ctr_pio_arb.sv
// Two-requester round-robin arbiter in front of a zero-wait PIO-style slave.
// Each transfer takes IDLE -> ACCESS -> RESP. The winner's op, address and
// write data are latched in IDLE. The slave is strobed in ACCESS. The
// granted requester is released in RESP together with the captured read data.
module lms_ctr_pio_arb #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  // requester 0
  input  logic              rq0_read,
  input  logic              rq0_write,
  input  logic [ADDR_W-1:0] rq0_address,
  input  logic [DATA_W-1:0] rq0_writedata,
  output logic [DATA_W-1:0] rq0_readdata,
  output logic              rq0_waitrequest,
  // requester 1
  input  logic              rq1_read,
  input  logic              rq1_write,
  input  logic [ADDR_W-1:0] rq1_address,
  input  logic [DATA_W-1:0] rq1_writedata,
  output logic [DATA_W-1:0] rq1_readdata,
  output logic              rq1_waitrequest,
  // slave side
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic              r_last_grant;   // port served by the most recent transfer
  logic              r_grant;        // port owning the transfer in flight
  logic              r_op_write;     // latched op: 1 = write (read+write counts as write)
  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] r_writedata;
  logic [DATA_W-1:0] r_rq0_readdata;
  logic [DATA_W-1:0] r_rq1_readdata;

  logic              w_req0;
  logic              w_req1;
  logic              w_any_req;
  logic              w_winner;
  logic              w_win_write;
  logic [ADDR_W-1:0] w_win_address;
  logic [DATA_W-1:0] w_win_writedata;
  logic [DATA_W-1:0] w_capture;

  assign w_req0    = rq0_read | rq0_write;
  assign w_req1    = rq1_read | rq1_write;
  assign w_any_req = w_req0 | w_req1;

  // A write returns zero. A read returns whatever the slave drives during ACCESS.
  assign w_capture = r_op_write ? '0 : m_readdata;

  // Round-robin pick: a lone requester wins, and a tie goes to the port not served last.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_winner = 1'b0;
    if (w_req0 && w_req1) begin
      w_winner = ~r_last_grant;
    end else if (w_req1) begin
      w_winner = 1'b1;
    end
    w_win_write     = w_winner ? rq1_write     : rq0_write;
    w_win_address   = w_winner ? rq1_address   : rq0_address;
    w_win_writedata = w_winner ? rq1_writedata : rq0_writedata;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: leave IDLE on any request, then run ACCESS and RESP for one cycle each.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:   if (w_any_req) w_next_state = S_ACCESS;
      S_ACCESS: w_next_state = S_RESP;
      S_RESP:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Latch the winner's request on the IDLE -> ACCESS transition.
  // Address and write data hold their values until the next grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_op_write   <= 1'b0;
      r_address    <= '0;
      r_writedata  <= '0;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_last_grant <= w_winner;
      r_grant      <= w_winner;
      r_op_write   <= w_win_write;
      r_address    <= w_win_address;
      r_writedata  <= w_win_writedata;
    end
  end

  // Capture the slave data at the end of ACCESS into the granted port's register.
  // That register becomes visible in RESP and then holds its value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rq0_readdata <= '0;
      r_rq1_readdata <= '0;
    end else if (r_state == S_ACCESS) begin
      if (r_grant) r_rq1_readdata <= w_capture;
      else         r_rq0_readdata <= w_capture;
    end
  end

  // Output decode: strobe the slave in ACCESS and release the granted port in RESP.
  always_comb begin
    m_chipselect    = 1'b0;
    m_write_n       = 1'b1;
    rq0_waitrequest = 1'b1;
    rq1_waitrequest = 1'b1;
    if (r_state == S_ACCESS) begin
      m_chipselect = 1'b1;
      m_write_n    = ~r_op_write;
    end
    if (r_state == S_RESP) begin
      rq0_waitrequest = r_grant;
      rq1_waitrequest = ~r_grant;
    end
  end

  assign m_address    = r_address;
  assign m_writedata  = r_writedata;
  assign rq0_readdata = r_rq0_readdata;
  assign rq1_readdata = r_rq1_readdata;

endmodule

// File: tb/tb_lms_ctr_pio_arb.sv
// Testbench for lms_ctr_pio_arb. The slave is a small register file.
// The reference model predicts grant order and returned data at the
// transaction level, using arbitration rules and an array image of the slave.
module tb_lms_ctr_pio_arb;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;

  typedef struct {
    logic        r0;
    logic        w0;
    logic [2:0]  a0;
    logic [31:0] d0;
    logic        r1;
    logic        w1;
    logic [2:0]  a1;
    logic [31:0] d1;
    int          exp_first;   // port expected to be served first
    logic [31:0] exp_rd0;     // expected rq0_readdata at its RESP
    logic [31:0] exp_rd1;     // expected rq1_readdata at its RESP
  } vec_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              rq0_read = 1'b0, rq0_write = 1'b0;
  logic [ADDR_W-1:0] rq0_address = '0;
  logic [DATA_W-1:0] rq0_writedata = '0;
  logic [DATA_W-1:0] rq0_readdata;
  logic              rq0_waitrequest;
  logic              rq1_read = 1'b0, rq1_write = 1'b0;
  logic [ADDR_W-1:0] rq1_address = '0;
  logic [DATA_W-1:0] rq1_writedata = '0;
  logic [DATA_W-1:0] rq1_readdata;
  logic              rq1_waitrequest;
  logic [ADDR_W-1:0] m_address;
  logic              m_chipselect;
  logic              m_write_n;
  logic [DATA_W-1:0] m_writedata;
  logic [DATA_W-1:0] m_readdata;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] ref_mem [8] = '{default: 32'h0};
  logic [31:0] hold [2]    = '{32'h0, 32'h0};
  bit          model_lg    = 1'b1;

  // slave: zero-wait register file with combinational read data
  logic [31:0] slave_mem [8] = '{default: 32'h0};
  assign m_readdata = slave_mem[m_address];
  always @(posedge clk) begin
    if (m_chipselect && !m_write_n) slave_mem[m_address] <= m_writedata;
  end

  always #5 clk = ~clk;

  lms_ctr_pio_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rq0_read        (rq0_read),
    .rq0_write       (rq0_write),
    .rq0_address     (rq0_address),
    .rq0_writedata   (rq0_writedata),
    .rq0_readdata    (rq0_readdata),
    .rq0_waitrequest (rq0_waitrequest),
    .rq1_read        (rq1_read),
    .rq1_write       (rq1_write),
    .rq1_address     (rq1_address),
    .rq1_writedata   (rq1_writedata),
    .rq1_readdata    (rq1_readdata),
    .rq1_waitrequest (rq1_waitrequest),
    .m_address       (m_address),
    .m_chipselect    (m_chipselect),
    .m_write_n       (m_write_n),
    .m_writedata     (m_writedata),
    .m_readdata      (m_readdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic get_wait(input int p);
    return (p == 0) ? rq0_waitrequest : rq1_waitrequest;
  endfunction

  function automatic logic [31:0] get_rdata(input int p);
    return (p == 0) ? rq0_readdata : rq1_readdata;
  endfunction

  task automatic drop_port(input int p);
    if (p == 0) begin rq0_read = 1'b0; rq0_write = 1'b0; end
    else        begin rq1_read = 1'b0; rq1_write = 1'b0; end
  endtask

  // Transaction-level prediction: who wins, and what each served port gets back.
  function automatic void predict(input vec_t vin, output vec_t vout);
    logic [31:0] mem [8];
    bit          req [2];
    bit          wr [2];
    logic [2:0]  ad [2];
    logic [31:0] da [2];
    logic [31:0] rd [2];
    int          first;
    int          p;
    mem = ref_mem;
    vout = vin;
    req[0] = vin.r0 | vin.w0; req[1] = vin.r1 | vin.w1;
    wr[0] = vin.w0; wr[1] = vin.w1;
    ad[0] = vin.a0; ad[1] = vin.a1;
    da[0] = vin.d0; da[1] = vin.d1;
    rd[0] = 32'h0;  rd[1] = 32'h0;
    if (req[0] && req[1]) first = model_lg ? 0 : 1;
    else if (req[1])      first = 1;
    else                  first = 0;
    for (int t = 0; t < 2; t++) begin
      p = (t == 0) ? first : 1 - first;
      if (req[p]) begin
        rd[p] = wr[p] ? 32'h0 : mem[ad[p]];
        if (wr[p]) mem[ad[p]] = da[p];
      end
    end
    vout.exp_first = first;
    vout.exp_rd0   = rd[0];
    vout.exp_rd1   = rd[1];
  endfunction

  // Apply one round from an IDLE negedge and check every cycle.
  // Timeline: ACCESS at +1 and RESP at +2 for the first port.
  // If both ports request: IDLE at +3, ACCESS at +4 and RESP at +5 for the second.
  // The task returns at the following IDLE negedge.
  task automatic run_round(input string tag, input vec_t v);
    logic        rq [2];
    logic        wr [2];
    logic [2:0]  ad [2];
    logic [31:0] da [2];
    logic [31:0] erd [2];
    int          n;
    int          p;
    rq[0] = v.r0 | v.w0; rq[1] = v.r1 | v.w1;
    wr[0] = v.w0; wr[1] = v.w1;
    ad[0] = v.a0; ad[1] = v.a1;
    da[0] = v.d0; da[1] = v.d1;
    erd[0] = v.exp_rd0; erd[1] = v.exp_rd1;
    rq0_read = v.r0; rq0_write = v.w0; rq0_address = v.a0; rq0_writedata = v.d0;
    rq1_read = v.r1; rq1_write = v.w1; rq1_address = v.a1; rq1_writedata = v.d1;
    n = int'(rq[0]) + int'(rq[1]);
    if (n == 0) begin
      @(negedge clk);
      check({tag, " idle_cs"}, 32'(m_chipselect), 32'd0);
      check({tag, " idle_wait0"}, 32'(rq0_waitrequest), 32'd1);
      check({tag, " idle_wait1"}, 32'(rq1_waitrequest), 32'd1);
    end
    for (int t = 0; t < n; t++) begin
      p = (t == 0) ? v.exp_first : 1 - v.exp_first;
      if (t == 1) begin
        @(negedge clk);
        check({tag, " gap_cs"}, 32'(m_chipselect), 32'd0);
        check({tag, " gap_addr_hold"}, 32'(m_address), 32'(ad[1-p]));
        check({tag, " gap_wait"}, {30'd0, rq1_waitrequest, rq0_waitrequest}, 32'd3);
      end
      @(negedge clk);
      check($sformatf("%s acc%0d_cs", tag, t), 32'(m_chipselect), 32'd1);
      check($sformatf("%s acc%0d_write_n", tag, t), 32'(m_write_n), 32'(!wr[p]));
      check($sformatf("%s acc%0d_addr", tag, t), 32'(m_address), 32'(ad[p]));
      check($sformatf("%s acc%0d_wdata", tag, t), m_writedata, da[p]);
      check($sformatf("%s acc%0d_wait", tag, t), {30'd0, rq1_waitrequest, rq0_waitrequest}, 32'd3);
      @(negedge clk);
      check($sformatf("%s resp%0d_cs", tag, t), 32'(m_chipselect), 32'd0);
      check($sformatf("%s resp%0d_write_n", tag, t), 32'(m_write_n), 32'd1);
      check($sformatf("%s resp%0d_wait_granted", tag, t), 32'(get_wait(p)), 32'd0);
      check($sformatf("%s resp%0d_wait_other", tag, t), 32'(get_wait(1 - p)), 32'd1);
      check($sformatf("%s resp%0d_rdata", tag, t), get_rdata(p), erd[p]);
      check($sformatf("%s resp%0d_rdata_other_hold", tag, t), get_rdata(1 - p), hold[1-p]);
      hold[p]  = erd[p];
      model_lg = p[0];
      if (wr[p]) ref_mem[ad[p]] = da[p];
      drop_port(p);
    end
    if (n > 0) begin
      @(negedge clk);
      check({tag, " end_idle_cs"}, 32'(m_chipselect), 32'd0);
    end
  endtask

  vec_t tbl [11];

  initial begin
    vec_t v;
    vec_t vp;
    int   first;
    int   p;
    int   op0;
    int   op1;

    // contention right after reset, then assorted single/dual patterns
    tbl[0]  = '{1'b0, 1'b1, 3'd1, 32'h11,       1'b0, 1'b1, 3'd2, 32'h22,       0, 32'h0,        32'h0};
    tbl[1]  = '{1'b0, 1'b1, 3'd0, 32'h1,        1'b0, 1'b0, 3'd0, 32'h0,        0, 32'h0,        32'h0};
    tbl[2]  = '{1'b0, 1'b0, 3'd0, 32'h0,        1'b1, 1'b0, 3'd0, 32'h0,        1, 32'h0,        32'h1};
    tbl[3]  = '{1'b0, 1'b1, 3'd1, 32'hA,        1'b0, 1'b1, 3'd2, 32'hB,        0, 32'h0,        32'h0};
    tbl[4]  = '{1'b1, 1'b0, 3'd1, 32'h0,        1'b1, 1'b0, 3'd2, 32'h0,        0, 32'hA,        32'hB};
    tbl[5]  = '{1'b1, 1'b1, 3'd4, 32'h1,        1'b0, 1'b0, 3'd0, 32'h0,        0, 32'h0,        32'hB};
    tbl[6]  = '{1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 3'd0, 32'h0,        0, 32'h0,        32'hB};
    tbl[7]  = '{1'b0, 1'b0, 3'd0, 32'h0,        1'b1, 1'b0, 3'd4, 32'h0,        1, 32'h0,        32'h1};
    tbl[8]  = '{1'b0, 1'b1, 3'd3, 32'hDEADBEEF, 1'b1, 1'b0, 3'd3, 32'h0,        0, 32'h0,        32'hDEADBEEF};
    tbl[9]  = '{1'b1, 1'b0, 3'd7, 32'h0,        1'b0, 1'b0, 3'd0, 32'h0,        0, 32'h0,        32'hDEADBEEF};
    tbl[10] = '{1'b1, 1'b0, 3'd3, 32'h0,        1'b1, 1'b0, 3'd1, 32'h0,        1, 32'hDEADBEEF, 32'hA};

    // reset state
    @(negedge clk);
    check("rst_cs", 32'(m_chipselect), 32'd0);
    check("rst_write_n", 32'(m_write_n), 32'd1);
    check("rst_addr", 32'(m_address), 32'd0);
    check("rst_wdata", m_writedata, 32'd0);
    check("rst_rdata0", rq0_readdata, 32'd0);
    check("rst_rdata1", rq1_readdata, 32'd0);
    check("rst_wait", {30'd0, rq1_waitrequest, rq0_waitrequest}, 32'd3);
    @(negedge clk);
    reset_n = 1'b1;

    // directed table
    for (int i = 0; i < 11; i++) run_round($sformatf("vec%0d", i), tbl[i]);
    check("slave_set_bits_addr4", slave_mem[4], 32'h1);

    // streaming: both ports request continuously for 8 transfers
    rq0_write = 1'b1; rq0_read = 1'b0; rq0_address = 3'd5; rq0_writedata = 32'h55;
    rq1_write = 1'b1; rq1_read = 1'b0; rq1_address = 3'd6; rq1_writedata = 32'h66;
    first = model_lg ? 0 : 1;
    for (int k = 0; k < 8; k++) begin
      p = first ^ (k & 1);
      if (k > 0) begin
        @(negedge clk);
        check($sformatf("stream%0d idle_cs", k), 32'(m_chipselect), 32'd0);
      end
      @(negedge clk);
      check($sformatf("stream%0d acc_cs", k), 32'(m_chipselect), 32'd1);
      check($sformatf("stream%0d acc_addr", k), 32'(m_address), (p == 0) ? 32'd5 : 32'd6);
      @(negedge clk);
      check($sformatf("stream%0d wait_granted", k), 32'(get_wait(p)), 32'd0);
      check($sformatf("stream%0d wait_other", k), 32'(get_wait(1 - p)), 32'd1);
      if (k == 7) begin drop_port(0); drop_port(1); end
    end
    model_lg = 1'(first ^ 1);
    hold[0] = 32'h0; hold[1] = 32'h0;
    ref_mem[5] = 32'h55; ref_mem[6] = 32'h66;
    @(negedge clk);
    check("stream_end_cs", 32'(m_chipselect), 32'd0);

    // reset asserted mid-ACCESS aborts; held requests complete after release
    v = '{1'b1, 1'b0, 3'd3, 32'h0, 1'b0, 1'b1, 3'd2, 32'h12345678, 0, 32'h0, 32'h0};
    rq0_read = v.r0; rq0_write = v.w0; rq0_address = v.a0; rq0_writedata = v.d0;
    rq1_read = v.r1; rq1_write = v.w1; rq1_address = v.a1; rq1_writedata = v.d1;
    @(negedge clk);
    check("midrst_acc_cs", 32'(m_chipselect), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_cs", 32'(m_chipselect), 32'd0);
    check("midrst_write_n", 32'(m_write_n), 32'd1);
    check("midrst_addr", 32'(m_address), 32'd0);
    check("midrst_wdata", m_writedata, 32'd0);
    check("midrst_rdata", rq0_readdata | rq1_readdata, 32'd0);
    check("midrst_wait", {30'd0, rq1_waitrequest, rq0_waitrequest}, 32'd3);
    @(negedge clk);
    check("midrst_hold_wait", {30'd0, rq1_waitrequest, rq0_waitrequest}, 32'd3);
    check("midrst_hold_cs", 32'(m_chipselect), 32'd0);
    check("midrst_no_slave_write", slave_mem[2], ref_mem[2]);
    reset_n = 1'b1;
    model_lg = 1'b1;
    hold[0] = 32'h0; hold[1] = 32'h0;
    predict(v, vp);
    check("midrst_model_port0_first", 32'(vp.exp_first), 32'd0);
    run_round("after_rst", vp);

    // randomized rounds against the transaction-level model
    for (int i = 0; i < 40; i++) begin
      op0 = $urandom_range(0, 3);
      op1 = $urandom_range(0, 3);
      v.r0 = op0[0]; v.w0 = op0[1]; v.a0 = 3'($urandom_range(0, 7)); v.d0 = $urandom;
      v.r1 = op1[0]; v.w1 = op1[1]; v.a1 = 3'($urandom_range(0, 7)); v.d1 = $urandom;
      v.exp_first = 0; v.exp_rd0 = 32'h0; v.exp_rd1 = 32'h0;
      predict(v, vp);
      run_round($sformatf("rnd%0d", i), vp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // run-time bound
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
